vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Source end of vga_if: generates hcount/vcount/hsync/vsync/hblnk/vblnk for 1024x768@60 (65 MHz pixel clk).
//  Drives the head of the draw chain; downstream stages (background, sprites) consume vga_if.in.
//  Also owns the level select: accepts level requests via valid/ready and applies them only at vblank
//  start, so a frame is never drawn with a mixed background.
// PARAMETERS
//  H_VISIBLE  1024  active pixels per line
//  H_FP       24    horizontal front porch (pixels)
//  H_SYNC     136   hsync width (pixels)
//  H_TOTAL    1344  pixels per line incl. blanking
//  V_VISIBLE  768   active lines per frame
//  V_FP       3     vertical front porch (lines)
//  V_SYNC     6     vsync width (lines)
//  V_TOTAL    806   lines per frame incl. blanking
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous, active-low reset
//  level_req    in   2   requested level index
//  level_valid  in   1   level_req is valid
//  level_ready  out  1   block can accept a request
//  level        out  2   level applied to the current frame (to background drawer)
//  frame_start  out  1   one-cycle pulse with hcount==0 && vcount==0
//  vga_out      out  vga_if.out  timing bundle; rgb tied 12'h000
//  frame_cnt    out  16  frames completed (only with VGA_TIMING_FRAME_CNT_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): hcount=0, vcount=0, all syncs/blanks=0, rgb=0, level=0, level_ready=1,
//    frame_start=0, frame_cnt=0. Reset mid-frame restarts at (0,0) on first clk after release.
//  - hcount 0..H_TOTAL-1, wraps to 0; vcount increments on hcount wrap, wraps 0 after V_TOTAL-1.
//  - All outputs registered; syncs/blanks are decoded from the NEXT counter values, so each output
//    is aligned with the hcount/vcount on the same cycle (zero relative skew, 1 clk after reset release).
//  - hblnk = hcount>=H_VISIBLE; hsync = hcount in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] = [1048,1183].
//  - vblnk = vcount>=V_VISIBLE; vsync = vcount in [771,776]. Syncs active-high; pin polarity set at top.
//  - Level FSM: IDLE (level_ready=1) -> PENDING on level_valid&&level_ready (capture level_req,
//    level_ready=0 next cycle). PENDING -> IDLE at vblank start (vcount==768, hcount==0 on outputs):
//    level updates on that same cycle, level_ready=1 the following cycle.
//  - Request accepted on the exact vblank-start cycle: not applied this frame; held to next vblank start.
//  - level_valid while PENDING: ignored (not ready); requester must hold valid until handshake.
//  - Requesting the current level is legal; still goes through PENDING/apply.
// CONFIGURATION
//  VGA_TIMING_FRAME_CNT_EN defined: port frame_cnt present; increments by 1 on each frame_start
//  (first frame_start after reset gives 1); wraps 16'hFFFF->0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  vga_pkg: H_*/V_* timing constants (parameter defaults) and level_t enum (LEVEL_0..LEVEL_3).
//  Counters and decode inline; level handshake FSM as sub-module vga_level_latch
//  (ports: clk, rst_n, level_req, level_valid, level_ready, apply, level).
// TESTING
//  1. Release reset, run 1 frame -> hcount wraps after 1343, vcount after 805; 806*1344=1083264 clks/frame.
//  2. Sample line 0 -> hblnk high for hcount 1024..1343; hsync high exactly hcount 1048..1183 (136 clks).
//  3. Sample frame -> vblnk high for vcount 768..805; vsync high exactly vcount 771..776.
//  4. level_req=1, valid at (vcount=100) -> ready drops, level stays 0 until (768,0), then level=1, ready=1 next clk.
//  5. level_req=2 accepted exactly at (768,0) -> level unchanged this frame, becomes 2 at next (768,0).
//  6. Assert rst_n=0 at (400,500) -> outputs zero immediately; after release count restarts at (0,0);
//     with VGA_TIMING_FRAME_CNT_EN, frame_cnt=0 then 1 at first frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: default XGA (1024x768@60) raster timing and the level index type.
package vga_pkg;

  localparam int VGA_H_VISIBLE = 1024;
  localparam int VGA_H_FP      = 24;
  localparam int VGA_H_SYNC    = 136;
  localparam int VGA_H_TOTAL   = 1344;
  localparam int VGA_V_VISIBLE = 768;
  localparam int VGA_V_FP      = 3;
  localparam int VGA_V_SYNC    = 6;
  localparam int VGA_V_TOTAL   = 806;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    LEVEL_0,
    LEVEL_1,
    LEVEL_2,
    LEVEL_3
  } level_t;

endpackage

// File: rtl/vga_level_latch.sv
// vga_level_latch: valid/ready level request that only takes effect on the apply strobe.
// state   | meaning
// IDLE    | ready high, waiting for level_valid
// PENDING | request captured, waiting for apply (vblank start)
// SETTLE  | level just updated, ready returns next cycle
module vga_level_latch
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] level_req,
  input  logic       level_valid,
  output logic       level_ready,
  input  logic       apply,
  output logic [1:0] level
);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SETTLE
  } state_t;

  state_t state;
  level_t req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_q       <= LEVEL_0;
      level       <= LEVEL_0;
      level_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (level_valid && level_ready) begin
            req_q       <= level_t'(level_req);
            level_ready <= 1'b0;
            state       <= PENDING;
          end
        end
        PENDING: begin
          if (apply) begin
            level <= req_q;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          level_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          level_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source with frame-aligned level select.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_TOTAL   = VGA_H_TOTAL,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_TOTAL   = VGA_V_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       level_req,
  input  logic             level_valid,
  output logic             level_ready,
  output logic [1:0]       level,
  output logic             frame_start,
  output logic [CNT_W-1:0] hcount,
  output logic             hsync,
  output logic             hblnk,
  output logic [CNT_W-1:0] vcount,
  output logic             vsync,
  output logic             vblnk,
  output logic [11:0]      rgb
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BLNK_START = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_BLNK_START = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic             running;
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             frame_nxt;
  logic             apply;

  // The first clock after reset presents (0,0) itself, so frame 0 gets its frame_start.
  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_nxt  = '0;
    v_nxt  = '0;
    if (running) begin
      h_nxt = h_wrap ? '0 : hcount + CNT_W'(1);
      v_nxt = !h_wrap ? vcount : (v_wrap ? '0 : vcount + CNT_W'(1));
    end
  end

  assign frame_nxt = (h_nxt == '0) && (v_nxt == '0);
  assign apply     = (h_nxt == '0) && (v_nxt == V_BLNK_START);
  assign rgb       = 12'h000;

  // Decode from the next counter values so every flag lines up with its count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running     <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hblnk       <= 1'b0;
      hsync       <= 1'b0;
      vblnk       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      running     <= 1'b1;
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hblnk       <= (h_nxt >= H_BLNK_START);
      hsync       <= (h_nxt >= H_SYNC_START) && (h_nxt < H_SYNC_END);
      vblnk       <= (v_nxt >= V_BLNK_START);
      vsync       <= (v_nxt >= V_SYNC_START) && (v_nxt < V_SYNC_END);
      frame_start <= frame_nxt;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_nxt) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  vga_level_latch u_level_latch (
    .clk         (clk),
    .rst_n       (rst_n),
    .level_req   (level_req),
    .level_valid (level_valid),
    .level_ready (level_ready),
    .apply       (apply),
    .level       (level)
  );

endmodule
